// File: rtl/register_file_mp.sv
// Multi-port register file with registered reads, write-to-read bypass and a busy scoreboard.
// Optional per-entry even parity with error injection is enabled by defining REGFILE_PARITY_EN.

// One read lane: looks up the bypass-merged view and registers the result.
module register_file_rd_port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     en,
    input  logic [ADDR_WIDTH-1:0]                    addr,
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] view,
    input  logic [2**ADDR_WIDTH-1:0]                 busy_view,
    input  logic [2**ADDR_WIDTH-1:0]                 perr_view,
    output logic [DATA_WIDTH-1:0]                    data,
    output logic                                     valid,
    output logic                                     busy,
    output logic                                     perr
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            perr  <= 1'b0;
        end else begin
            valid <= en;
            busy  <= en & busy_view[addr];
            perr  <= en & perr_view[addr];
            if (en) data <= view[addr];
        end
    end
endmodule

module register_file_mp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         rsv_en,
    input  logic [ADDR_WIDTH-1:0]        rsv_addr,
    output logic [2**ADDR_WIDTH-1:0]     busy_vec,
    input  logic                         par_inj,
    output logic [NUM_RD-1:0]            rd_perr
);
    localparam int NREG = 2**ADDR_WIDTH;

    logic [NREG-1:0][DATA_WIDTH-1:0] regs, wr_val;
    logic [NREG-1:0]                 busy_q, busy_clr, busy_nxt, wr_hit;
    logic [NREG-1:0]                 perr_view;

    // wr_val is the post-write register image; it doubles as the bypass source.
    // Ascending port order lets the highest-index port win on collisions.
    always_comb begin
        wr_hit = '0;
        wr_val = regs;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
                wr_hit[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
                wr_val[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A same-cycle reserve beats the clear: the reserver is the newer producer.
    always_comb begin
        busy_clr = busy_q & ~wr_hit;
        busy_nxt = busy_clr;
        if (rsv_en && rsv_addr != '0) busy_nxt[rsv_addr] = 1'b1;
    end

`ifdef REGFILE_PARITY_EN
    logic [NREG-1:0] par_q, wr_par;

    always_comb begin
        wr_par = par_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0)
                wr_par[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = ^wr_data[p*DATA_WIDTH +: DATA_WIDTH] ^ par_inj;
        end
        perr_view = '0;
        for (int i = 1; i < NREG; i++) perr_view[i] = ^wr_val[i] ^ wr_par[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) par_q <= '0;
        else        par_q <= wr_par;
    end
`else
    logic par_inj_unused;
    assign par_inj_unused = par_inj;
    assign perr_view      = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs   <= '0;
            busy_q <= '0;
        end else begin
            regs   <= wr_val;
            busy_q <= busy_nxt;
        end
    end

    assign busy_vec = busy_q;

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        register_file_rd_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_rd (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (rd_en[r]),
            .addr      (rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]),
            .view      (wr_val),
            .busy_view (busy_clr),
            .perr_view (perr_view),
            .data      (rd_data[r*DATA_WIDTH +: DATA_WIDTH]),
            .valid     (rd_valid[r]),
            .busy      (rd_busy[r]),
            .perr      (rd_perr[r])
        );
    end
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp (default 8-bit, 8-entry, 2R/2W configuration).
module tb_register_file_mp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  rd_en;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic [1:0]  rd_valid, rd_busy, rd_perr;
    logic        rsv_en;
    logic [2:0]  rsv_addr;
    logic [7:0]  busy_vec;
    logic        par_inj;

    int n_chk  = 0;
    int n_fail = 0;

    register_file_mp dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_busy(rd_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec),
        .par_inj(par_inj), .rd_perr(rd_perr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return (i == 0) ? 8'h00 : 8'(8'hA0 + i);
    endfunction

    initial begin
        rst_n = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0; rsv_en = 1'b0; rsv_addr = '0; par_inj = 1'b0;
        tick(); tick();
        check("rst_valid", {14'd0, rd_valid}, 16'h0000);
        check("rst_data",  rd_data, 16'h0000);
        check("rst_busy",  {8'd0, busy_vec}, 16'h0000);
        check("rst_perr",  {14'd0, rd_perr}, 16'h0000);
        rst_n = 1'b1;

        // Read every address on both ports after reset.
        for (int a = 0; a < 8; a++) begin
            rd_en = 2'b11; rd_addr = {3'(a), 3'(a)};
            tick();
            check("t1_valid", {14'd0, rd_valid}, 16'h0003);
            check("t1_data",  rd_data, 16'h0000);
        end
        check("t1_busy", {8'd0, busy_vec}, 16'h0000);

        // Fill 1..7 through port 0, then read i / 7-i.
        rd_en = 2'b00;
        for (int i = 1; i < 8; i++) begin
            wr_en = 2'b01; wr_addr = {3'd0, 3'(i)}; wr_data = {8'h00, pat(i)};
            tick();
        end
        wr_en = 2'b00;
        for (int i = 0; i < 8; i++) begin
            rd_en = 2'b11; rd_addr = {3'(7 - i), 3'(i)};
            tick();
            check("t2_data", rd_data, {pat(7 - i), pat(i)});
        end
        rd_en = 2'b00;
        tick();
        check("t2_idle_valid", {14'd0, rd_valid}, 16'h0000);
        check("t2_hold_data",  rd_data, 16'h00A7);

        // Dual write collision with same-cycle read: port 1 wins and bypasses.
        wr_en = 2'b11; wr_addr = {3'd3, 3'd3}; wr_data = 16'h2211;
        rd_en = 2'b01; rd_addr = {3'd0, 3'd3};
        tick();
        check("t3_bypass", {8'd0, rd_data[7:0]}, 16'h0022);
        wr_en = 2'b00;
        tick();
        check("t3_stored", {8'd0, rd_data[7:0]}, 16'h0022);

        // Writes to address 0 are dropped, including the bypass path.
        wr_en = 2'b11; wr_addr = 6'd0; wr_data = 16'hFFFF;
        rd_en = 2'b11; rd_addr = 6'd0;
        tick();
        check("t4_bypass0", rd_data, 16'h0000);
        check("t4_busy",    {8'd0, busy_vec}, 16'h0000);
        wr_en = 2'b00;
        tick();
        check("t4_read0", rd_data, 16'h0000);

        // Scoreboard.
        rd_en = 2'b00; rsv_en = 1'b1; rsv_addr = 3'd5;
        tick();
        check("t5_rsv", {8'd0, busy_vec}, 16'h0020);
        rsv_en = 1'b0; rd_en = 2'b01; rd_addr = {3'd0, 3'd5};
        tick();
        check("t5_rd_busy", {14'd0, rd_busy}, 16'h0001);
        rd_en = 2'b00; wr_en = 2'b01; wr_addr = {3'd0, 3'd5}; wr_data = 16'h005A;
        rsv_en = 1'b1; rsv_addr = 3'd5;
        tick();
        check("t5_rsv_wins", {8'd0, busy_vec}, 16'h0020);
        rsv_en = 1'b0; wr_en = 2'b10; wr_addr = {3'd5, 3'd0}; wr_data = 16'h5B00;
        rd_en = 2'b01; rd_addr = {3'd0, 3'd5};
        tick();
        check("t5_clear",        {8'd0, busy_vec}, 16'h0000);
        check("t5_bypass_data",  {8'd0, rd_data[7:0]}, 16'h005B);
        check("t5_bypass_busy",  {14'd0, rd_busy}, 16'h0000);
        wr_en = 2'b00; rd_en = 2'b00; rsv_en = 1'b1; rsv_addr = 3'd0;
        tick();
        check("t5_rsv0", {8'd0, busy_vec}, 16'h0000);
        rsv_en = 1'b0;

        // Parity injection.
        wr_en = 2'b01; wr_addr = {3'd0, 3'd2}; wr_data = 16'h003C; par_inj = 1'b1;
        tick();
        wr_en = 2'b00; par_inj = 1'b0; rd_en = 2'b01; rd_addr = {3'd0, 3'd2};
        tick();
        check("t6_data", {8'd0, rd_data[7:0]}, 16'h003C);
`ifdef REGFILE_PARITY_EN
        check("t6_perr_inj", {14'd0, rd_perr}, 16'h0001);
        wr_en = 2'b01; wr_addr = {3'd0, 3'd2}; wr_data = 16'h003C; par_inj = 1'b0;
        tick();
        check("t6_perr_bypass_clean", {14'd0, rd_perr}, 16'h0000);
        wr_en = 2'b00;
        tick();
        check("t6_perr_clean", {14'd0, rd_perr}, 16'h0000);
        wr_en = 2'b10; wr_addr = {3'd4, 3'd0}; wr_data = 16'h0100; par_inj = 1'b1;
        rd_en = 2'b11; rd_addr = {3'd4, 3'd0};
        tick();
        check("t6_perr_bypass_inj", {14'd0, rd_perr}, 16'h0002);
        wr_en = 2'b00; par_inj = 1'b0;
`else
        check("t6_perr_off", {14'd0, rd_perr}, 16'h0000);
`endif

        // Reset while a read is in flight.
        wr_en = 2'b00; rsv_en = 1'b1; rsv_addr = 3'd6;
        rd_en = 2'b11; rd_addr = {3'd2, 3'd1};
        tick();
        check("t7_inflight", {14'd0, rd_valid}, 16'h0003);
        rsv_en = 1'b0; rst_n = 1'b0;
        tick();
        check("t7_rst_valid", {14'd0, rd_valid}, 16'h0000);
        check("t7_rst_data",  rd_data, 16'h0000);
        check("t7_rst_busy",  {8'd0, busy_vec}, 16'h0000);
        rst_n = 1'b1; rd_en = 2'b11; rd_addr = {3'd2, 3'd1};
        tick();
        check("t7_regs_clear", rd_data, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
